// File: rtl/aoc4_mem_arbiter_pkg.sv
// Shared types and sizing for the AoC4 banked grid memory arbiter.
package aoc4_mem_arbiter_pkg;

    localparam int NUM_BANKS      = 3;
    localparam int BANK_DEPTH     = 64;
    localparam int TX_DATA_WIDTH  = 32;
    localparam int COL_ADDR_WIDTH = 8;
    localparam int MEM_LATENCY    = 1;

    localparam int ROW_W      = $clog2(NUM_BANKS * BANK_DEPTH);
    localparam int BANK_ROW_W = $clog2(BANK_DEPTH);
    localparam int BANK_IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int WORD_SHIFT = $clog2(TX_DATA_WIDTH);
    localparam int WORD_W     = COL_ADDR_WIDTH - WORD_SHIFT;
    localparam int WAIT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef struct packed {
        logic                      write;
        logic [ROW_W-1:0]          row;
        logic [COL_ADDR_WIDTH-1:0] col;
        logic [TX_DATA_WIDTH-1:0]  wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/aoc4_mem_arbiter_if.sv
// One requester port of the grid memory arbiter: request fields in, ack/busy/err/rdata out.
interface aoc4_mem_arbiter_if;
    import aoc4_mem_arbiter_pkg::*;

    logic                      valid;
    logic                      write;
    logic [ROW_W-1:0]          row;
    logic [COL_ADDR_WIDTH-1:0] col;
    logic [TX_DATA_WIDTH-1:0]  wdata;
    logic                      ack;
    logic                      busy;
    logic                      err;
    logic [TX_DATA_WIDTH-1:0]  rdata;

    modport master (
        output valid, write, row, col, wdata,
        input  ack, busy, err, rdata
    );

    modport slave (
        input  valid, write, row, col, wdata,
        output ack, busy, err, rdata
    );

endinterface

// File: rtl/aoc4_mem_arbiter_row_map.sv
// Grid row -> {bank index, row inside bank, in-range flag}; purely combinational.
module aoc4_mem_arbiter_row_map
    import aoc4_mem_arbiter_pkg::*;
(
    input  logic [ROW_W-1:0]      i_row,
    output logic [BANK_IDX_W-1:0] o_bank_idx,
    output logic [BANK_ROW_W-1:0] o_bank_row,
    output logic                  o_in_range
);

    localparam logic [ROW_W-1:0] NB    = ROW_W'(NUM_BANKS);
    localparam logic [ROW_W-1:0] DEPTH = ROW_W'(BANK_DEPTH);

    logic [ROW_W-1:0] w_quot;

    assign w_quot     = i_row / NB;
    assign o_bank_idx = BANK_IDX_W'(i_row % NB);
    assign o_bank_row = BANK_ROW_W'(w_quot);
    // row < NUM_BANKS*BANK_DEPTH is the same test as quotient < BANK_DEPTH.
    assign o_in_range = (w_quot < DEPTH);

endmodule

// File: rtl/aoc4_mem_arbiter.sv
// Two-port arbiter for the AoC4 banked grid memory: one single-word access at a time,
// port A has absolute priority while staging, otherwise round-robin on ties.
module aoc4_mem_arbiter
    import aoc4_mem_arbiter_pkg::*;
(
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               i_staging,
    aoc4_mem_arbiter_if.slave                  a_if,
    aoc4_mem_arbiter_if.slave                  b_if,
    output logic                               o_busy,
    output logic [NUM_BANKS-1:0]               o_bank_re,
    output logic [NUM_BANKS-1:0]               o_bank_we,
    output logic [BANK_ROW_W-1:0]              o_bank_row,
    output logic [WORD_W-1:0]                  o_bank_word,
    output logic [TX_DATA_WIDTH-1:0]           o_bank_wdata,
    input  logic [NUM_BANKS*TX_DATA_WIDTH-1:0] i_bank_rdata
);

    arb_state_t                r_state;
    arb_state_t                w_next_state;
    mem_req_t                  r_req;
    port_t                     r_grant;
    port_t                     r_rr_last;
    logic                      r_served_a;
    logic                      r_served_b;
    logic                      r_err;
    logic [WAIT_W-1:0]         r_wait_cnt;
    logic [TX_DATA_WIDTH-1:0]  r_rdata;

    mem_req_t                  w_req_a;
    mem_req_t                  w_req_b;
    logic                      w_elig_a;
    logic                      w_elig_b;
    logic                      w_grant_any;
    port_t                     w_grant_sel;
    logic [BANK_IDX_W-1:0]     w_bank_idx;
    logic [BANK_ROW_W-1:0]     w_bank_row;
    logic                      w_in_range;
    logic [NUM_BANKS-1:0]      w_bank_sel;
    logic [NUM_BANKS-1:0][TX_DATA_WIDTH-1:0] w_rdata_banks;

    assign w_req_a       = {a_if.write, a_if.row, a_if.col, a_if.wdata};
    assign w_req_b       = {b_if.write, b_if.row, b_if.col, b_if.wdata};
    assign w_rdata_banks = i_bank_rdata;
    assign w_bank_sel    = NUM_BANKS'(1) << w_bank_idx;

    assign w_elig_a    = a_if.valid & ~r_served_a;
    assign w_elig_b    = b_if.valid & ~r_served_b & ~i_staging;
    assign w_grant_any = w_elig_a | w_elig_b;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_grant_sel = PORT_A;
        if (w_elig_a && w_elig_b) begin
            w_grant_sel = (r_rr_last == PORT_A) ? PORT_B : PORT_A;
        end else if (w_elig_b) begin
            w_grant_sel = PORT_B;
        end
    end

    aoc4_mem_arbiter_row_map u_row_map (
        .i_row      (r_req.row),
        .o_bank_idx (w_bank_idx),
        .o_bank_row (w_bank_row),
        .o_in_range (w_in_range)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant_any) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT:  if (r_wait_cnt == '0) w_next_state = ST_ACK;
            ST_ACK:   w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_req      <= '0;
            r_grant    <= PORT_A;
            r_rr_last  <= PORT_B;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_grant   <= w_grant_sel;
                        r_rr_last <= w_grant_sel;
                        r_req     <= (w_grant_sel == PORT_A) ? w_req_a : w_req_b;
                    end
                end
                ST_ISSUE: begin
                    r_err      <= ~w_in_range;
                    r_wait_cnt <= WAIT_W'(MEM_LATENCY - 1);
                end
                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_rdata <= (r_req.write || !w_in_range) ? '0 : w_rdata_banks[w_bank_idx];
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A served flag blocks re-grant until the requester drops valid for a cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_served_a <= 1'b0;
            r_served_b <= 1'b0;
        end else begin
            if (!a_if.valid)                                  r_served_a <= 1'b0;
            else if (r_state == ST_ACK && r_grant == PORT_A)  r_served_a <= 1'b1;
            if (!b_if.valid)                                  r_served_b <= 1'b0;
            else if (r_state == ST_ACK && r_grant == PORT_B)  r_served_b <= 1'b1;
        end
    end

    always_comb begin
        o_busy       = (r_state != ST_IDLE);
        o_bank_re    = '0;
        o_bank_we    = '0;
        o_bank_row   = '0;
        o_bank_word  = '0;
        o_bank_wdata = '0;
        a_if.ack     = 1'b0;
        a_if.err     = 1'b0;
        a_if.rdata   = '0;
        b_if.ack     = 1'b0;
        b_if.err     = 1'b0;
        b_if.rdata   = '0;
        a_if.busy    = (r_state != ST_IDLE) && (r_grant == PORT_A);
        b_if.busy    = (r_state != ST_IDLE) && (r_grant == PORT_B);
        case (r_state)
            ST_ISSUE: begin
                if (w_in_range) begin
                    if (r_req.write) o_bank_we = w_bank_sel;
                    else             o_bank_re = w_bank_sel;
                    o_bank_row   = w_bank_row;
                    o_bank_word  = WORD_W'(r_req.col >> WORD_SHIFT);
                    o_bank_wdata = r_req.write ? r_req.wdata : '0;
                end
            end
            ST_ACK: begin
                if (r_grant == PORT_A) begin
                    a_if.ack   = 1'b1;
                    a_if.err   = r_err;
                    a_if.rdata = r_rdata;
                end else begin
                    b_if.ack   = 1'b1;
                    b_if.err   = r_err;
                    b_if.rdata = r_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aoc4_mem_arbiter.sv
// Scoreboarded bench for aoc4_mem_arbiter: a row-level grid model predicts every ack,
// a monitor compares whenever a port acks, and a bank model serves the strobes.
module tb_aoc4_mem_arbiter;
    import aoc4_mem_arbiter_pkg::*;

    localparam int NUM_ROWS = NUM_BANKS * BANK_DEPTH;
    localparam int WORDS    = 1 << WORD_W;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic staging = 1'b0;
    always #5 clock = ~clock;

    aoc4_mem_arbiter_if a_if ();
    aoc4_mem_arbiter_if b_if ();

    logic                                    busy;
    logic [NUM_BANKS-1:0]                    bank_re;
    logic [NUM_BANKS-1:0]                    bank_we;
    logic [BANK_ROW_W-1:0]                   bank_row;
    logic [WORD_W-1:0]                       bank_word;
    logic [TX_DATA_WIDTH-1:0]                bank_wdata;
    logic [NUM_BANKS-1:0][TX_DATA_WIDTH-1:0] bank_rdata = '0;

    aoc4_mem_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .i_staging    (staging),
        .a_if         (a_if),
        .b_if         (b_if),
        .o_busy       (busy),
        .o_bank_re    (bank_re),
        .o_bank_we    (bank_we),
        .o_bank_row   (bank_row),
        .o_bank_word  (bank_word),
        .o_bank_wdata (bank_wdata),
        .i_bank_rdata (bank_rdata)
    );

    logic                      drv_valid [2];
    logic                      drv_write [2];
    logic [ROW_W-1:0]          drv_row   [2];
    logic [COL_ADDR_WIDTH-1:0] drv_col   [2];
    logic [31:0]               drv_wdata [2];

    assign a_if.valid = drv_valid[0];
    assign a_if.write = drv_write[0];
    assign a_if.row   = drv_row[0];
    assign a_if.col   = drv_col[0];
    assign a_if.wdata = drv_wdata[0];
    assign b_if.valid = drv_valid[1];
    assign b_if.write = drv_write[1];
    assign b_if.row   = drv_row[1];
    assign b_if.col   = drv_col[1];
    assign b_if.wdata = drv_wdata[1];

    logic [1:0]  p_ack, p_busy, p_err;
    logic [31:0] p_rdata [2];
    assign p_ack      = {b_if.ack,  a_if.ack};
    assign p_busy     = {b_if.busy, a_if.busy};
    assign p_err      = {b_if.err,  a_if.err};
    assign p_rdata[0] = a_if.rdata;
    assign p_rdata[1] = b_if.rdata;

    // Reference model: the whole grid as a flat word array, plus per-port expectations.
    logic [31:0] grid [NUM_ROWS*WORDS] = '{default: '0};
    exp_t exp_q0[$];
    exp_t exp_q1[$];

    // Bank device model: read data valid exactly one cycle after the read strobe.
    logic [31:0] bank_mem [NUM_BANKS][BANK_DEPTH][WORDS] = '{default: '0};
    int strobe_cnt = 0;
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int ack_cnt [2] = '{0, 0};
    int last_ack_cyc [2] = '{0, 0};
    int lat_last [2] = '{0, 0};
    int ack_order[$];

    always @(posedge clock) cyc++;

    always @(posedge clock) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_rdata[b] <= $urandom;
            if (bank_we[b]) bank_mem[b][bank_row][bank_word] <= bank_wdata;
            else if (bank_re[b]) bank_rdata[b] <= bank_mem[b][bank_row][bank_word];
        end
        if ((bank_re | bank_we) != '0) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_issue(input int p, input bit wr, input int row,
                                        input int col, input logic [31:0] wd);
        exp_t e;
        int idx;
        idx     = row * WORDS + col / TX_DATA_WIDTH;
        e.err   = (row >= NUM_ROWS);
        e.rdata = '0;
        if (!e.err) begin
            if (wr) grid[idx] = wd;
            else    e.rdata = grid[idx];
        end
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endfunction

    task automatic mon(input int p);
        exp_t e;
        int sz;
        string nm;
        nm = (p == 0) ? "a" : "b";
        sz = (p == 0) ? exp_q0.size() : exp_q1.size();
        ack_cnt[p]++;
        last_ack_cyc[p] = cyc;
        ack_order.push_back(p);
        check({nm, "_ack_expected"}, 32'(sz != 0), 1);
        check({nm, "_busy_in_ack"}, 32'(p_busy[p]), 1);
        if (sz != 0) begin
            if (p == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check({nm, "_rdata"}, p_rdata[p], e.rdata);
            check({nm, "_err"}, 32'(p_err[p]), 32'(e.err));
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (p_ack[0]) mon(0);
            if (p_ack[1]) mon(1);
            if ((bank_re | bank_we) != '0) begin
                check("strobe_onehot", 32'($onehot(bank_re | bank_we)), 1);
                check("strobe_busy", 32'(busy), 1);
            end
        end
    end

    // Drive one request, hold valid until ack (+hold_extra cycles), then drop for one cycle.
    task automatic issue(input int p, input bit wr, input int row, input int col,
                         input logic [31:0] wd, input int hold_extra);
        int n;
        n = 0;
        model_issue(p, wr, row, col, wd);
        drv_write[p] = wr;
        drv_row[p]   = ROW_W'(row);
        drv_col[p]   = COL_ADDR_WIDTH'(col);
        drv_wdata[p] = wd;
        drv_valid[p] = 1'b1;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!p_ack[p] && n < 200);
        check((p == 0) ? "a_ack_timeout" : "b_ack_timeout", 32'(p_ack[p]), 1);
        lat_last[p] = n;
        repeat (1 + hold_extra) begin
            @(posedge clock); #1;
        end
        drv_valid[p] = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic rand_traffic(input int p, input int count);
        int row, col, gap;
        bit wr;
        for (int k = 0; k < count; k++) begin
            wr  = 1'($urandom_range(0, 1));
            row = ($urandom_range(0, 9) == 0) ? $urandom_range(NUM_ROWS, 255)
                : (p == 0) ? $urandom_range(0, NUM_ROWS/2 - 1)
                           : $urandom_range(NUM_ROWS/2, NUM_ROWS - 1);
            col = $urandom_range(0, (1 << COL_ADDR_WIDTH) - 1);
            gap = $urandom_range(0, 2);
            issue(p, wr, row, col, $urandom, $urandom_range(0, 1));
            repeat (gap) begin
                @(posedge clock); #1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, s0, stg_cyc;
        for (int p = 0; p < 2; p++) begin
            drv_valid[p] = 1'b0;
            drv_write[p] = 1'b0;
            drv_row[p]   = '0;
            drv_col[p]   = '0;
            drv_wdata[p] = '0;
        end

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_re", 32'(bank_re), 0);
        check("rst_we", 32'(bank_we), 0);
        check("rst_row", 32'(bank_row), 0);
        check("rst_wdata", bank_wdata, 0);
        check("rst_acks", 32'(p_ack), 0);
        check("rst_port_busy", 32'(p_busy), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // 1: staged write to row 4 -> bank 1, bank row 1, ack three cycles after sampling
        staging = 1'b1;
        fork
            issue(0, 1'b1, 4, 0, 32'hA5A5_0001, 0);
        join_none
        @(negedge clock);
        check("t1_no_we_in_idle", 32'(bank_we), 0);
        @(negedge clock);
        check("t1_we", 32'(bank_we), 32'b010);
        check("t1_re", 32'(bank_re), 0);
        check("t1_bank_row", 32'(bank_row), 1);
        check("t1_bank_word", 32'(bank_word), 0);
        check("t1_wdata", bank_wdata, 32'hA5A5_0001);
        wait fork;
        check("t1_latency", lat_last[0], 3);

        // 2: read back, valid held one cycle past ack -> exactly one ack
        c0 = ack_cnt[0];
        issue(0, 1'b0, 4, 0, '0, 1);
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("t2_single_ack", ack_cnt[0] - c0, 1);

        // 3: B is locked out while staging, then served promptly once staging falls
        c0 = ack_cnt[1];
        fork
            issue(1, 1'b0, 0, 0, '0, 0);
        join_none
        issue(0, 1'b1, 10, 32, 32'h1234_5678, 0);
        repeat (4) begin
            @(posedge clock); #1;
        end
        check("t3_b_blocked", ack_cnt[1] - c0, 0);
        staging = 1'b0;
        stg_cyc = cyc;
        wait fork;
        check("t3_b_acked", ack_cnt[1] - c0, 1);
        check("t3_b_within_4", 32'((last_ack_cyc[1] - stg_cyc) <= 4), 1);

        // 4: both ports re-request continuously -> A,B,A,B,... starting with A
        ack_order.delete();
        fork
            for (int k = 0; k < 4; k++) issue(0, k[0], 20 + k / 2, 64, 32'hAA00_0000 + k, 0);
            for (int k = 0; k < 4; k++) issue(1, k[0], 100 + k / 2, 128, 32'hBB00_0000 + k, 0);
        join
        check("t4_count", ack_order.size(), 8);
        for (int i = 0; i < 8 && i < ack_order.size(); i++)
            check("t4_order", ack_order[i], i % 2);

        // 5: out-of-range read -> no strobe, err with zero data
        s0 = strobe_cnt;
        issue(0, 1'b0, NUM_ROWS, 0, '0, 0);
        check("t5_no_strobe", strobe_cnt - s0, 0);

        // 6: reset during WAIT aborts the access; a fresh request then completes
        drv_write[0] = 1'b0;
        drv_row[0]   = ROW_W'(5);
        drv_col[0]   = 8'd64;
        drv_valid[0] = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("t6_busy_in_wait", 32'(busy), 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("t6_busy_cleared", 32'(busy), 0);
        check("t6_no_ack", 32'(p_ack), 0);
        check("t6_no_strobe", 32'(bank_re | bank_we), 0);
        check("t6_port_busy", 32'(p_busy), 0);
        reset = 1'b0;
        drv_valid[0] = 1'b0;
        @(posedge clock); #1;
        issue(0, 1'b0, 5, 64, '0, 0);
        check("t6_fresh_latency", lat_last[0], 3);

        // Randomised traffic from both ports on disjoint halves of the grid
        fork
            rand_traffic(0, 40);
            rand_traffic(1, 40);
        join

        repeat (5) begin
            @(posedge clock); #1;
        end
        check("sb_a_drained", exp_q0.size(), 0);
        check("sb_b_drained", exp_q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
